// File: rtl/seg_scan_display.sv
// Multiplexed hex seven-segment scanner with frame-synchronous load handshake.
// Optional macro SEG_BLANK_LEADING_ZERO_EN blanks digits above the most significant nonzero nibble.
module seg_scan_display #(
    parameter int DIGITS = 4,
    parameter int N      = 17
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    output logic                  ack,
    output logic                  frame,
    output logic [DIGITS-1:0]     an,
    output logic [7:0]            seg
);

    localparam int            IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

    logic [N-1:0]        presc_q, presc_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] disp_q;
    logic [DIGITS-1:0]   dp_q;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [7:0]          seg_q, seg_d;
    logic                ack_q, frame_q;

    logic                tick;
    logic                boundary;
    logic                capture;
    logic [3:0]          nibble;
    logic                blank;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // A load request is only honoured on the last tick of a full scan, so a capture never tears a frame.
    always_comb begin
        presc_d  = presc_q + N'(1);
        tick     = &presc_q;
        boundary = tick && (idx_q == LAST);
        capture  = boundary && load;
        idx_d    = idx_q;
        if (tick) begin
            idx_d = (idx_q == LAST) ? '0 : idx_q + IW'(1);
        end
    end

`ifdef SEG_BLANK_LEADING_ZERO_EN
    logic [IW-1:0] msd;

    always_comb begin
        msd = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (disp_q[4*k +: 4] != 4'h0) begin
                msd = IW'(k);
            end
        end
        blank = (idx_q > msd);
    end
`else
    always_comb begin
        blank = 1'b0;
    end
`endif

    always_comb begin
        nibble = disp_q[4*int'(idx_q) +: 4];
        an_d   = ~(DIGITS'(1) << idx_q);
        seg_d  = {~dp_q[idx_q], blank ? 7'b1111111 : hex7(nibble)};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= '0;
            disp_q  <= '0;
            dp_q    <= '0;
            an_q    <= '1;
            seg_q   <= 8'hFF;
            ack_q   <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            if (capture) begin
                disp_q <= value;
                dp_q   <= dp;
            end
            an_q    <= an_d;
            seg_q   <= seg_d;
            ack_q   <= capture;
            frame_q <= boundary;
        end
    end

    assign an    = an_q;
    assign seg   = seg_q;
    assign ack   = ack_q;
    assign frame = frame_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display (DIGITS=4, N=4) against a cycle-count reference model.
// Honours SEG_BLANK_LEADING_ZERO_EN the same way the design does.
module tb_seg_scan_display;

    localparam int D   = 4;
    localparam int PER = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp = 4'h0;
    logic        ack, frame;
    logic [3:0]  an;
    logic [7:0]  seg;

    int checks = 0;
    int errors = 0;

    int          cyc = 0;
    logic [15:0] mDisp = 16'h0;
    logic [3:0]  mDp = 4'h0;
    logic [3:0]  expAn = 4'hF;
    logic [7:0]  expSeg = 8'hFF;
    logic        expAck = 1'b0;
    logic        expFrame = 1'b0;

    seg_scan_display #(.DIGITS(D), .N(4)) dut (
        .clk(clk), .reset(reset), .load(load), .value(value), .dp(dp),
        .ack(ack), .frame(frame), .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] model_seg(input logic [15:0] disp, input logic [3:0] dpv, input int idx);
        string      lit;
        logic [6:0] s;
        int         top;
        int         nib;
        top = 0;
        for (int k = 0; k < D; k++) begin
            if (((disp >> (4*k)) & 16'hF) != 0) top = k;
        end
        nib = int'((disp >> (4*idx)) & 16'hF);
        case (nib)
            0: lit = "abcdef";   1: lit = "bc";      2: lit = "abdeg";   3: lit = "abcdg";
            4: lit = "bcfg";     5: lit = "acdfg";   6: lit = "acdefg";  7: lit = "abc";
            8: lit = "abcdefg";  9: lit = "abcdfg";  10: lit = "abcefg"; 11: lit = "cdefg";
            12: lit = "adef";    13: lit = "bcdeg";  14: lit = "adefg";  default: lit = "aefg";
        endcase
        s = 7'h7F;
        for (int i = 0; i < lit.len(); i++) s[int'(lit[i]) - 97] = 1'b0;
`ifdef SEG_BLANK_LEADING_ZERO_EN
        if (idx > top) s = 7'h7F;
`endif
        return {~dpv[idx], s};
    endfunction

    // Reference: digit index and frame boundary follow directly from the cycle count since reset.
    always @(posedge clk or posedge reset) begin
        int  idx;
        bit  bnd;
        if (reset) begin
            cyc = 0; mDisp = 16'h0; mDp = 4'h0;
            expAn = 4'hF; expSeg = 8'hFF; expAck = 1'b0; expFrame = 1'b0;
        end else begin
            idx      = (cyc / PER) % D;
            bnd      = ((cyc + 1) % (PER * D)) == 0;
            expAn    = 4'hF & ~(4'b0001 << idx);
            expSeg   = model_seg(mDisp, mDp, idx);
            expFrame = bnd;
            expAck   = bnd && load;
            if (bnd && load) begin
                mDisp = value;
                mDp   = dp;
            end
            cyc++;
        end
    end

    task automatic test_reset();
        #3 reset = 1'b1;
        #1;
        checks++; if (an !== 4'hF) begin errors++; $display("FAIL reset_an got %b want 1111", an); end
        checks++; if (seg !== 8'hFF) begin errors++; $display("FAIL reset_seg got %h want ff", seg); end
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", ack); end
        checks++; if (frame !== 1'b0) begin errors++; $display("FAIL reset_frame got %b want 0", frame); end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (an !== 4'b1110) begin errors++; $display("FAIL release_an got %b want 1110", an); end
        checks++; if (seg !== 8'hC0) begin errors++; $display("FAIL release_seg got %h want c0", seg); end
    endtask

    task automatic test_hold_load();
        logic [7:0] want[4];
        bit         found;
        want = '{8'h8E, 8'h88, 8'hA4, 8'hF9};
        @(negedge clk);
        load = 1'b1; value = 16'h12AF; dp = 4'b0000;
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (ack === 1'b1) found = 1;
        end
        load = 1'b0;
        checks++; if (!found) begin errors++; $display("FAIL hold_ack_wait got none want ack within 200 cycles"); end
        @(negedge clk);
        for (int d = 0; d < D; d++) begin
            for (int c = 0; c < PER; c++) begin
                checks++;
                if (an !== (4'hF & ~(4'b0001 << d)) || seg !== want[d]) begin
                    errors++;
                    $display("FAIL hold_scan digit %0d step %0d got an=%b seg=%h want seg=%h", d, c, an, seg, want[d]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_frame();
        int count = 0;
        int last = -1;
        for (int c = 0; c < 256; c++) begin
            @(negedge clk);
            checks++; if (frame !== expFrame) begin errors++; $display("FAIL frame_cycle %0d got %b want %b", c, frame, expFrame); end
            if (frame === 1'b1) begin
                if (last >= 0) begin
                    checks++; if (c - last != 64) begin errors++; $display("FAIL frame_spacing got %0d want 64", c - last); end
                end
                last = c;
                count++;
            end
        end
        checks++; if (count != 4) begin errors++; $display("FAIL frame_count got %0d want 4", count); end
    endtask

    task automatic test_blank();
        logic [7:0] want[4];
        bit         found;
`ifdef SEG_BLANK_LEADING_ZERO_EN
        want = '{8'h92, 8'hFF, 8'hFF, 8'hFF};
`else
        want = '{8'h92, 8'hC0, 8'hC0, 8'hC0};
`endif
        @(negedge clk);
        load = 1'b1; value = 16'h0005; dp = 4'b0000;
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (ack === 1'b1) found = 1;
        end
        load = 1'b0;
        checks++; if (!found) begin errors++; $display("FAIL blank_ack_wait got none want ack within 200 cycles"); end
        @(negedge clk);
        for (int d = 0; d < D; d++) begin
            for (int c = 0; c < PER; c++) begin
                checks++;
                if (an !== (4'hF & ~(4'b0001 << d)) || seg !== want[d]) begin
                    errors++;
                    $display("FAIL blank_scan digit %0d got an=%b seg=%h want seg=%h", d, an, seg, want[d]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_dp();
        logic [7:0] want[4];
        bit         found;
        want = '{8'h80, 8'h80, 8'h00, 8'h80};
        @(negedge clk);
        load = 1'b1; value = 16'h8888; dp = 4'b0100;
        found = 0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            if (ack === 1'b1) found = 1;
        end
        load = 1'b0;
        checks++; if (!found) begin errors++; $display("FAIL dp_ack_wait got none want ack within 200 cycles"); end
        @(negedge clk);
        for (int d = 0; d < D; d++) begin
            for (int c = 0; c < PER; c++) begin
                checks++;
                if (an !== (4'hF & ~(4'b0001 << d)) || seg !== want[d]) begin
                    errors++;
                    $display("FAIL dp_scan digit %0d got an=%b seg=%h want seg=%h", d, an, seg, want[d]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        int wantAcks = 0;
        int last = -1;
        @(negedge clk);
        load = 1'b1; value = 16'hC3D9; dp = 4'b1001;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            checks++; if (ack !== expAck) begin errors++; $display("FAIL b2b_ack cycle %0d got %b want %b", c, ack, expAck); end
            if (expAck) wantAcks++;
            if (ack === 1'b1) begin
                if (last >= 0) begin
                    checks++; if (c - last != 64) begin errors++; $display("FAIL b2b_spacing got %0d want 64", c - last); end
                end
                last = c;
                acks++;
            end
        end
        load = 1'b0;
        checks++; if (acks != wantAcks || acks < 3) begin errors++; $display("FAIL b2b_count got %0d want %0d (at least 3)", acks, wantAcks); end
    endtask

    task automatic test_random();
        int holdLeft = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            checks++;
            if (an !== expAn || seg !== expSeg || ack !== expAck || frame !== expFrame) begin
                errors++;
                $display("FAIL random cycle %0d got an=%b seg=%h ack=%b frame=%b want an=%b seg=%h ack=%b frame=%b",
                         c, an, seg, ack, frame, expAn, expSeg, expAck, expFrame);
            end
            if (load) begin
                if (holdLeft == 0) load = 1'b0;
                else holdLeft--;
            end else if ($urandom_range(0, 29) == 0) begin
                load     = 1'b1;
                value    = 16'($urandom);
                dp       = 4'($urandom_range(0, 15));
                holdLeft = $urandom_range(3, 150);
            end
        end
        load = 1'b0;
    endtask

    task automatic test_reset_mid_request();
        int   k = 0;
        logic [7:0] wantHi;
`ifdef SEG_BLANK_LEADING_ZERO_EN
        wantHi = 8'hFF;
`else
        wantHi = 8'hC0;
`endif
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        while (k < 58) begin
            @(negedge clk);
            k++;
            if (k == 10) begin
                load = 1'b1; value = 16'hBEEF; dp = 4'b1111;
            end
        end
        #2 reset = 1'b1;
        #1;
        checks++; if (an !== 4'hF || seg !== 8'hFF || ack !== 1'b0 || frame !== 1'b0) begin
            errors++; $display("FAIL midreq_async got an=%b seg=%h ack=%b frame=%b want 1111 ff 0 0", an, seg, ack, frame);
        end
        repeat (3) @(negedge clk);
        load = 1'b0; reset = 1'b0;
        for (int c = 0; c < 160; c++) begin
            @(negedge clk);
            checks++; if (ack !== 1'b0) begin errors++; $display("FAIL midreq_ack cycle %0d got %b want 0", c, ack); end
            checks++;
            if (seg !== ((an === 4'b1110) ? 8'hC0 : wantHi) || seg !== expSeg) begin
                errors++; $display("FAIL midreq_seg cycle %0d an=%b got %h want %h", c, an, seg, expSeg);
            end
        end
    endtask

    initial begin
        $display("[TB] seg_scan_display bench start");
        test_reset();
        test_hold_load();
        test_frame();
        test_blank();
        test_dp();
        test_back_to_back();
        test_random();
        test_reset_mid_request();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_display.md
SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, number of multiplexed digits, legal range 1..8.
REQ-002 The block SHALL have parameter N, default 17, prescaler width in bits, legal range 2..24.
REQ-003 Port clk, input, 1, the single system clock; all state SHALL be clocked on its rising edge.
REQ-004 Port reset, input, 1; reset is asynchronous and active-high.
REQ-005 Port load, input, 1, level request to capture value/dp into the display register.
REQ-006 Port value, input, 4*DIGITS, hex nibbles; nibble k = value[4k+3:4k] drives digit k.
REQ-007 Port dp, input, DIGITS, bit k = 1 lights the decimal point of digit k.
REQ-008 Port ack, output, 1, one-cycle pulse confirming capture of a load request.
REQ-009 Port frame, output, 1, one-cycle pulse at each completed scan of all digits.
REQ-010 Port an, output, DIGITS, active-low digit enables, registered.
REQ-011 Port seg, output, 8, active-low segments, registered; seg[7]=dp, seg[6:0]=g,f,e,d,c,b,a.

Function
REQ-012 An N-bit prescaler SHALL increment every cycle and wrap; tick SHALL be asserted in the cycle the prescaler equals all ones.
REQ-013 A digit index SHALL advance on tick, wrapping from DIGITS-1 to 0; with DIGITS=1 it stays 0.
REQ-014 The frame boundary SHALL be the cycle where tick is high and index equals DIGITS-1; frame SHALL pulse the following cycle.
REQ-015 Each cycle an/seg SHALL register: an bit index low, all others high; seg = hex decode of the indexed display nibble with seg[7] = ~dp bit; output latency from index change is one cycle.
REQ-016 Hex decode SHALL be standard with lowercase b,d; required codes (seg[6:0]): 0=1000000, 1=1111001, 2=0100100, 5=0010010, 8=0000000, A=0001000, F=0001110.
REQ-017 Capture SHALL occur only at a frame boundary while load=1; display register and dp register are written atomically from value/dp in that cycle, ack pulses the following cycle.
REQ-018 Load deasserted before a frame boundary SHALL drop the request with no capture and no ack; the requester holds value/dp stable while load is high.
REQ-019 Load held high across several boundaries SHALL capture and ack at each boundary.
REQ-020 An index or DIGITS value that would select a nonexistent digit SHALL never occur; the index SHALL be sized ceil(log2(DIGITS)), minimum 1 bit.

Reset
REQ-021 While reset is high: prescaler=0, index=0, display and dp registers=0, an=all ones, seg=8'hFF, ack=0, frame=0, any pending request discarded.
REQ-022 First cycle after reset release SHALL drive an with bit0 low and seg=8'hC0.
REQ-023 Reset asserted mid-scan or mid-request SHALL take effect immediately without waiting for clk.

Configuration
REQ-024 With SEG_BLANK_LEADING_ZERO_EN defined, digits above the most significant nonzero nibble of the display register SHALL drive seg[6:0]=1111111 (dp still honoured, an still scanned); digit 0 is never blanked.
REQ-025 Without SEG_BLANK_LEADING_ZERO_EN, every digit SHALL show its decoded nibble, zeros included.

Verification (DIGITS=4, N=4: tick every 16 cycles, frame every 64)
REQ-026 Assert reset -> an=4'b1111, seg=8'hFF, ack=0, frame=0; release -> next cycle an=4'b1110, seg=8'hC0.
REQ-027 Hold load=1, value=16'h12AF, dp=4'b0000 -> ack one cycle after first boundary; next scan shows an 1110/1101/1011/0111 with seg 8E/88/A4/F9, each held 16 cycles.
REQ-028 Free run 256 cycles -> frame pulses exactly 4 times, 64 cycles apart, each one cycle wide.
REQ-029 Load value=16'h0005 -> with macro, digits 3..1 seg=8'hFF, digit 0 seg=8'h92; without macro, digits 3..1 seg=8'hC0.
REQ-030 Load value=16'h8888, dp=4'b0100 -> digit 2 seg=8'h00, others seg=8'h80.
REQ-031 Raise load, assert reset 5 cycles before boundary -> no ack ever, display stays 0 (seg=8'hC0 without macro).
